// File: rtl/string_pattern_tx.sv
// Serial pattern transmitter: sends a PAT_W-bit pattern MSB first, rep times,
// with gap idle cycles between repetitions; all outputs registered.
module string_pattern_tx #(
  parameter int unsigned          PAT_W   = 4,
  parameter logic [PAT_W-1:0]     DEF_PAT = PAT_W'(4'b1101)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             use_def,
  input  logic [PAT_W-1:0] pat,
  input  logic [3:0]       rep,
  input  logic [2:0]       gap,
  output logic             x,
  output logic             mark,
  output logic             busy,
  output logic             done,
  output logic [3:0]       sent_cnt
);

  localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state, state_d;
  logic [IDX_W-1:0] idx, idx_d, idx_m1;
  logic [PAT_W-1:0] pat_q, pat_d, sel_pat;
  logic [3:0]       rep_q, rep_d;
  logic [2:0]       gap_q, gap_d, gcnt, gcnt_d;
  logic [3:0]       cnt_d, cnt_inc;
  logic             x_d, mark_d, busy_d, done_d;

  assign sel_pat = use_def ? DEF_PAT : pat;
  assign idx_m1  = idx - IDX_W'(1);
  assign cnt_inc = sent_cnt + 4'd1;

  // Next state and next registered outputs; idx is the bit currently on x
  always_comb begin
    state_d = state;
    idx_d   = idx;
    pat_d   = pat_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt;
    cnt_d   = sent_cnt;
    x_d     = 1'b0;
    mark_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          pat_d = sel_pat;
          rep_d = rep;
          gap_d = gap;
          cnt_d = 4'd0;
          busy_d = 1'b1;
          if (rep != 4'd0) begin
            state_d = S_SEND;
            idx_d   = IDX_MSB;
            x_d     = sel_pat[PAT_W-1];
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_SEND: begin
        busy_d = 1'b1;
        if (idx != '0) begin
          idx_d  = idx_m1;
          x_d    = pat_q[idx_m1];
          mark_d = (idx_m1 == '0);
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == rep_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (gap_q != 3'd0) begin
            state_d = S_GAP;
            gcnt_d  = gap_q - 3'd1;
          end else begin
            idx_d = IDX_MSB;
            x_d   = pat_q[PAT_W-1];
          end
        end
      end
      S_GAP: begin
        busy_d = 1'b1;
        if (gcnt == 3'd0) begin
          state_d = S_SEND;
          idx_d   = IDX_MSB;
          x_d     = pat_q[PAT_W-1];
        end else begin
          gcnt_d = gcnt - 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= S_IDLE;
      idx      <= '0;
      pat_q    <= '0;
      rep_q    <= '0;
      gap_q    <= '0;
      gcnt     <= '0;
      sent_cnt <= '0;
      x        <= 1'b0;
      mark     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      pat_q    <= pat_d;
      rep_q    <= rep_d;
      gap_q    <= gap_d;
      gcnt     <= gcnt_d;
      sent_cnt <= cnt_d;
      x        <= x_d;
      mark     <= mark_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_string_pattern_tx.sv
// Scoreboard bench for string_pattern_tx: stimulus queues expected per-cycle
// outputs, a negedge monitor pops one entry per busy cycle.
module tb_string_pattern_tx;

  logic       clk = 1'b0;
  logic       clr, start, use_def;
  logic [3:0] pat, rep;
  logic [2:0] gap;
  logic       x, mark, busy, done;
  logic [3:0] sent_cnt;

  typedef struct packed {
    logic       x;
    logic       mark;
    logic       done;
    logic [3:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] xlog;
  int          xlen;
  logic [3:0]  hist;
  int          det_hits;

  string_pattern_tx #(.PAT_W(4), .DEF_PAT(4'b1101)) dut (
    .clk(clk), .clr(clr), .start(start), .use_def(use_def), .pat(pat),
    .rep(rep), .gap(gap), .x(x), .mark(mark), .busy(busy), .done(done),
    .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-busy-cycle trace of one transmission
  task automatic push_tx(input logic [3:0] p, input int r, input int g);
    exp_t e;
    for (int j = 0; j < r; j++) begin
      for (int i = 0; i < 4; i++) begin
        e.x = p[3-i]; e.mark = (i == 3); e.done = 1'b0; e.cnt = 4'(j);
        sb.push_back(e);
      end
      if (j < r - 1)
        for (int k = 0; k < g; k++) begin
          e.x = 1'b0; e.mark = 1'b0; e.done = 1'b0; e.cnt = 4'(j + 1);
          sb.push_back(e);
        end
    end
    e.x = 1'b0; e.mark = 1'b0; e.done = 1'b1; e.cnt = 4'(r);
    sb.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!clr && busy) begin
      xlog = {xlog[30:0], x};
      xlen++;
      hist = {hist[2:0], x};
      if (hist == 4'b1101) begin
        det_hits++;
        check("det_on_mark", 32'(mark), 32'd1);
      end
      if (sb.size() == 0) begin
        check("unexpected_busy", 32'(busy), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("x", 32'(x), 32'(e.x));
        check("mark", 32'(mark), 32'(e.mark));
        check("done", 32'(done), 32'(e.done));
        check("sent_cnt", 32'(sent_cnt), 32'(e.cnt));
      end
    end else if (!clr) begin
      check("idle_outs", {29'd0, x, mark, done}, 32'd0);
    end
  end

  task automatic clear_log();
    xlog = '0; xlen = 0; hist = '0; det_hits = 0;
  endtask

  task automatic go(input logic ud, input logic [3:0] p, input logic [3:0] r, input logic [2:0] g);
    @(posedge clk); #2;
    use_def = ud; pat = p; rep = r; gap = g; start = 1'b1;
    clear_log();
    push_tx(ud ? 4'b1101 : p, int'(r), int'(g));
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (c < 300) begin
      @(posedge clk); #3;
      c++;
      if (sb.size() == 0 && !busy) break;
    end
    check({name, "_timeout"}, 32'(c < 300), 32'd1);
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; use_def = 1'b0; pat = '0; rep = '0; gap = '0;
    clear_log();
    repeat (2) @(posedge clk); #2;
    check("reset_outs", {25'd0, x, mark, busy, done, sent_cnt}, 32'd0);
    clr = 1'b0;

    // Single shot with default pattern
    go(1'b1, 4'b0000, 4'd1, 3'd0);
    wait_idle("t1");
    check("t1_stream", xlog, 32'(5'b11010));
    check("t1_len", 32'(xlen), 32'd5);
    check("t1_cnt_busy", {27'd0, busy, sent_cnt}, 32'h01);

    // Back-to-back repetitions
    go(1'b1, 4'b0000, 4'd2, 3'd0);
    wait_idle("t2");
    check("t2_stream", xlog, 32'(9'b110111010));
    check("t2_cnt", 32'(sent_cnt), 32'd2);

    // User pattern with gaps
    go(1'b0, 4'b1011, 4'd3, 3'd2);
    wait_idle("t3");
    check("t3_stream", xlog, 32'(17'b1011_00_1011_00_1011_0));
    check("t3_cnt", 32'(sent_cnt), 32'd3);

    // Loop-back detector: one hit per repetition of 1101
    go(1'b1, 4'b0000, 4'd3, 3'd2);
    wait_idle("t4");
    check("t4_det_hits", 32'(det_hits), 32'd3);

    // Start and inputs changing mid-SEND must be ignored
    go(1'b0, 4'b1001, 4'd2, 3'd1);
    @(posedge clk); #2;
    start = 1'b1; pat = 4'b1111; use_def = 1'b1; rep = 4'd7; gap = 3'd5;
    @(posedge clk); #2;
    start = 1'b0;
    wait_idle("t5");
    check("t5_stream", xlog, 32'(10'b1001010010));
    check("t5_cnt", 32'(sent_cnt), 32'd2);
    check("t5_cnt_hold", 32'(sent_cnt), 32'd2);

    // Reset during the second bit, start held through clr
    go(1'b1, 4'b0000, 4'd1, 3'd0);
    @(posedge clk); #2;
    clr = 1'b1;
    #1;
    check("t6_clr_outs", {25'd0, x, mark, busy, done, sent_cnt}, 32'd0);
    sb.delete();
    start = 1'b1; use_def = 1'b1; rep = 4'd1; gap = 3'd0;
    @(posedge clk); #2;
    check("t6_start_in_clr", {30'd0, busy, done}, 32'd0);
    clear_log();
    push_tx(4'b1101, 1, 0);
    clr = 1'b0;
    @(posedge clk); #2;
    start = 1'b0;
    wait_idle("t6");
    check("t6_stream", xlog, 32'(5'b11010));
    check("t6_cnt", 32'(sent_cnt), 32'd1);

    // rep = 0 goes straight to DONE
    go(1'b1, 4'b0000, 4'd0, 3'd3);
    wait_idle("t7");
    check("t7_stream", xlog, 32'd0);
    check("t7_len", 32'(xlen), 32'd1);
    check("t7_cnt", 32'(sent_cnt), 32'd0);

    // Start held high: restart right after one IDLE cycle
    @(posedge clk); #2;
    use_def = 1'b0; pat = 4'b0110; rep = 4'd1; gap = 3'd0; start = 1'b1;
    clear_log();
    push_tx(4'b0110, 1, 0);
    push_tx(4'b0110, 1, 0);
    repeat (7) @(posedge clk);
    #2;
    start = 1'b0;
    wait_idle("t8");
    check("t8_stream", xlog, 32'(10'b01100_01100));
    check("t8_len", 32'(xlen), 32'd10);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
